// File: rtl/uart_telemetry_tx_pkg.sv
// uart_telemetry_tx_pkg: UART constants shared with the RX side and the TX FSM state type
package uart_telemetry_tx_pkg;
  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int UART_BAUD = 115_200;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/uart_telemetry_tx_fifo.sv
// uart_telemetry_tx_fifo: synchronous byte FIFO with occupancy level, ignores push when full and pop when empty
module uart_telemetry_tx_fifo
  import uart_telemetry_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rd_data = mem[rd_ptr];
  // storage array, no reset needed since level gates every read
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end
  // pointers wrap modulo depth; level tracks push/pop, unchanged when both fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
endmodule

// File: rtl/uart_telemetry_tx.sv
// uart_telemetry_tx: FIFO-buffered 8N1 UART transmitter, LSB first, registered TxD
module uart_telemetry_tx
  import uart_telemetry_tx_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_HZ,
  parameter int BAUD = UART_BAUD,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          TxD,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  tx_state_e state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift_reg, shift_n, fifo_rd;
  logic pop, full, empty, bit_end, txd_n;
  uart_telemetry_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (tx_valid),
    .wr_data (tx_data),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );
  assign tx_ready = !full;
  assign tx_busy = state != IDLE || fifo_level != '0;
  assign bit_end = baud_cnt == LAST;
  // TxD is registered from the current state, so the line lags the FSM by one clock uniformly
  assign txd_n = state == START ? 1'b0 : state == DATA ? shift_reg[0] : 1'b1;
  // next-state logic: pop on idle or on the last stop cycle so queued frames run gap-free
  always_comb begin
    state_n = state;
    baud_cnt_n = baud_cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n = shift_reg;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (!empty) begin
          pop = 1'b1;
          shift_n = fifo_rd;
          state_n = START;
        end
      end
      START: if (bit_end) begin
        baud_cnt_n = '0;
        bit_idx_n = '0;
        state_n = DATA;
      end
      DATA: if (bit_end) begin
        baud_cnt_n = '0;
        shift_n = shift_reg >> 1;
        bit_idx_n = bit_idx + 3'd1;
        state_n = bit_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        baud_cnt_n = '0;
        pop = !empty;
        shift_n = empty ? shift_reg : fifo_rd;
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counters, shifter and line flop; reset aborts any frame and drives the line high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_idx <= '0;
      shift_reg <= '0;
      TxD <= 1'b1;
    end else begin
      state <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx <= bit_idx_n;
      shift_reg <= shift_n;
      TxD <= txd_n;
    end
  end
endmodule

// File: tb/tb_uart_telemetry_tx.sv
// tb_uart_telemetry_tx: frame-level model of the transmitter plus directed literal checks
module tb_uart_telemetry_tx;
  localparam int DIV = 13;
  localparam int FRAME = 10 * DIV;
  localparam int DEPTH = 16;
  logic clk = 0, rst_n = 1, tx_valid = 0, tx_ready, TxD, tx_busy;
  logic [7:0] tx_data = 0;
  logic [4:0] fifo_level;
  int checks = 0, errors = 0;
  uart_telemetry_tx #(.CLK_FREQ(50_000_000), .BAUD(4_000_000), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .TxD        (TxD),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );
  always #10 clk = ~clk;
  logic [7:0] mq [$];
  bit m_act = 0;
  int m_age = 0, m_lvl = 0;
  logic [7:0] m_cur = 0;
  logic m_txd = 1, m_busy = 0;
  function automatic logic line_bit(bit act, int age, logic [7:0] cur);
    int idx = age / DIV;
    if (!act || idx == 9) return 1'b1;
    if (idx == 0) return 1'b0;
    return cur[idx-1];
  endfunction
  // model: a frame occupies FRAME clocks from the edge its byte leaves the queue; line lags one clock
  initial forever begin
    bit acc;
    logic nt;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_act = 0; m_age = 0; m_txd = 1; m_busy = 0; m_lvl = 0;
    end else begin
      acc = tx_valid && mq.size() != DEPTH;
      nt = line_bit(m_act, m_age, m_cur);
      if (!m_act || m_age == FRAME - 1) begin
        if (mq.size() != 0) begin
          m_cur = mq.pop_front(); m_act = 1; m_age = 0;
        end else m_act = 0;
      end else m_age++;
      if (acc) mq.push_back(tx_data);
      m_txd = nt;
      m_lvl = mq.size();
      m_busy = m_act || mq.size() != 0;
    end
  end
  // per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    checks++;
    if (TxD !== m_txd || tx_ready !== (m_lvl != DEPTH) || tx_busy !== m_busy || fifo_level !== 5'(m_lvl)) begin
      errors++;
      $display("FAIL cycle t=%0t: TxD=%b want %b ready=%b want %b busy=%b want %b level=%0d want %0d",
               $time, TxD, m_txd, tx_ready, m_lvl != DEPTH, tx_busy, m_busy, fifo_level, m_lvl);
    end
  end
  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] b);
    int n = 0;
    tx_data = b;
    tx_valid = 1;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("push_timeout", 1, 0);
    @(negedge clk);
    tx_valid = 0;
  endtask
  task automatic decode(output logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1;
    b = 0;
    while (TxD !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      ok = 0;
      return;
    end
    repeat (DIV / 2) @(negedge clk);
    if (TxD !== 1'b0) ok = 0;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      b[i] = TxD;
    end
    repeat (DIV) @(negedge clk);
    if (TxD !== 1'b1) ok = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (tx_busy && n < 40 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("drain", int'(tx_busy), 0);
  endtask
  initial begin
    logic [9:0] exp1;
    logic [7:0] b0, b1;
    bit ok0, ok1;
    int n;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset_txd", int'(TxD), 1);
    chk("reset_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_level", int'(fifo_level), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    // single byte 0x01: two-clock latency then start, 1, seven zeros, stop
    exp1 = 10'b1000000010;
    push(8'h01);
    chk("lat_k", int'(TxD), 1);
    @(negedge clk);
    chk("lat_k1", int'(TxD), 1);
    @(negedge clk);
    chk("lat_k2", int'(TxD), 0);
    repeat (DIV / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) repeat (DIV) @(negedge clk);
      chk($sformatf("bit%0d", i), int'(TxD), int'(exp1[i]));
    end
    repeat (DIV) @(negedge clk);
    chk("idle_txd", int'(TxD), 1);
    chk("idle_busy", int'(tx_busy), 0);
    // back-to-back pair with no gap
    push(8'hA5);
    push(8'h5A);
    n = 0;
    fork
      begin
        decode(b0, ok0);
        decode(b1, ok1);
      end
      begin
        while (tx_busy && n < 1000) begin
          @(negedge clk);
          n++;
        end
      end
    join
    chk("pair_busy_len", n, 2 * FRAME);
    chk("pair_b0", int'(b0), 'hA5);
    chk("pair_b1", int'(b1), 'h5A);
    chk("pair_ok", int'(ok0 && ok1), 1);
    drain();
    // fill: first byte leaves at once so 17 fit, the 18th waits for the next pop
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
    chk("full_level", int'(fifo_level), 16);
    chk("full_ready", int'(tx_ready), 0);
    push(8'h21);
    chk("refill_level", int'(fifo_level), 16);
    drain();
    // reset in the middle of a data bit with bytes queued
    push(8'h3C);
    push(8'hEE);
    push(8'hEF);
    repeat (4 * DIV) @(negedge clk);
    #3 rst_n = 0;
    #1;
    chk("abort_txd", int'(TxD), 1);
    chk("abort_level", int'(fifo_level), 0);
    chk("abort_busy", int'(tx_busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2 * FRAME) @(negedge clk);
    push(8'h55);
    decode(b0, ok0);
    chk("post_reset_byte", int'(b0), 'h55);
    chk("post_reset_ok", int'(ok0), 1);
    drain();
    // random bytes with random producer gaps, occasionally long enough to go idle
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i % 50 == 49) repeat (20 * FRAME) @(negedge clk);
      push(8'($urandom_range(0, 255)));
    end
    drain();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
